// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the IF/MEM unified-bus arbiter: state encodings
// and small helpers used by the FSM.
package mem_bus_arbiter_pkg;

  localparam logic [2:0] ARB_IDLE   = 3'd0;
  localparam logic [2:0] ARB_D_BUSY = 3'd1;
  localparam logic [2:0] ARB_D_DONE = 3'd2;
  localparam logic [2:0] ARB_I_BUSY = 3'd3;
  localparam logic [2:0] ARB_I_DONE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ARB_IDLE,
    S_D_BUSY = ARB_D_BUSY,
    S_D_DONE = ARB_D_DONE,
    S_I_BUSY = ARB_I_BUSY,
    S_I_DONE = ARB_I_DONE
  } arb_state_t;

  function automatic logic is_busy(arb_state_t s);
    return (s == S_D_BUSY) || (s == S_I_BUSY);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Core-side request/stall signals and bus-side handshake for the arbiter.
// master = arbiter view, slave = core plus bus environment view.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              inst_ren;
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] inst_data;
  logic              if_stall;

  logic              mem_ren;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dout;
  logic [DATA_W-1:0] mem_din;
  logic              mem_stall;

  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_err;

  modport master (
    input  inst_ren, inst_addr, mem_ren, mem_wen, mem_addr, mem_dout,
           bus_ack, bus_rdata,
    output inst_data, if_stall, mem_din, mem_stall,
           bus_req, bus_we, bus_addr, bus_wdata, bus_err
  );

  modport slave (
    output inst_ren, inst_addr, mem_ren, mem_wen, mem_addr, mem_dout,
           bus_ack, bus_rdata,
    input  inst_data, if_stall, mem_din, mem_stall,
           bus_req, bus_we, bus_addr, bus_wdata, bus_err
  );
endinterface

// File: rtl/mem_bus_arbiter_watchdog.sv
// Busy-cycle watchdog: down-counter reloaded while idle, flags expiry when
// the TIMEOUT-th busy cycle is reached.
module bus_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // Counts down to zero and sits there; zero during a busy cycle is expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= LOAD;
    end else if (clr) begin
      cnt <= LOAD;
    end else if (run && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expired = run && (cnt == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single-ported memory bus between instruction fetch and the
// data port, data first, with registered bus/data outputs and a watchdog.
//   state  | meaning
//   IDLE   | no access in flight
//   D_BUSY | data access on the bus, waiting for ack
//   D_DONE | data access finished, mem_stall released this cycle
//   I_BUSY | fetch on the bus, waiting for ack
//   I_DONE | fetch finished, if_stall released this cycle
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  mem_bus_arbiter_if.master   bif
);

  arb_state_t        state;
  logic              bus_req_q;
  logic              bus_we_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic [DATA_W-1:0] inst_data_q;
  logic [DATA_W-1:0] mem_din_q;
  logic              bus_err_q;

  logic dreq;
  logic ireq;
  logic launch_d;
  logic launch_i;
  logic busy;
  logic expired;

  assign dreq = bif.mem_ren | bif.mem_wen;
  assign ireq = bif.inst_ren;
  assign busy = is_busy(state);

  bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (!busy),
    .run     (busy),
    .expired (expired)
  );

  // After a data access the fetch goes next, and vice versa, so neither
  // port can starve the other under continuous traffic.
  always_comb begin
    launch_d = 1'b0;
    launch_i = 1'b0;
    case (state)
      S_IDLE, S_I_DONE: begin
        launch_d = dreq;
        launch_i = !dreq && ireq;
      end
      S_D_DONE: begin
        launch_i = ireq;
        launch_d = !ireq && dreq;
      end
      default: begin
        launch_d = 1'b0;
        launch_i = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      inst_data_q <= '0;
      mem_din_q   <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      case (state)
        S_D_BUSY: begin
          if (bif.bus_ack || expired) begin
            bus_req_q <= 1'b0;
            state     <= S_D_DONE;
            if (!bus_we_q) mem_din_q <= bif.bus_ack ? bif.bus_rdata : '0;
            if (!bif.bus_ack) bus_err_q <= 1'b1;
          end
        end
        S_I_BUSY: begin
          if (bif.bus_ack || expired) begin
            bus_req_q   <= 1'b0;
            state       <= S_I_DONE;
            inst_data_q <= bif.bus_ack ? bif.bus_rdata : '0;
            if (!bif.bus_ack) bus_err_q <= 1'b1;
          end
        end
        default: begin
          if (launch_d) begin
            state       <= S_D_BUSY;
            bus_req_q   <= 1'b1;
            bus_we_q    <= bif.mem_wen;
            bus_addr_q  <= bif.mem_addr;
            bus_wdata_q <= bif.mem_dout;
          end else if (launch_i) begin
            state      <= S_I_BUSY;
            bus_req_q  <= 1'b1;
            bus_we_q   <= 1'b0;
            bus_addr_q <= bif.inst_addr;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bif.if_stall  = ireq & (state != S_I_DONE);
  assign bif.mem_stall = dreq & (state != S_D_DONE);
  assign bif.bus_req   = bus_req_q;
  assign bif.bus_we    = bus_we_q;
  assign bif.bus_addr  = bus_addr_q;
  assign bif.bus_wdata = bus_wdata_q;
  assign bif.inst_data = inst_data_q;
  assign bif.mem_din   = mem_din_q;
  assign bif.bus_err   = bus_err_q;

endmodule
